// File: rtl/ps2_dir_queue_pkg.sv
// Shared direction encodings, PS/2 scancodes and decoder states for the snake
// direction queue.
package ps2_dir_queue_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_e;

    // Encodings pair up so the opposite direction differs only in the LSB.
    function automatic logic [1:0] dir_opposite(input logic [1:0] dir);
        return {dir[1], ~dir[0]};
    endfunction

endpackage

// File: rtl/ps2_dir_queue_dir_fifo.sv
// Small synchronous FIFO of directions; exposes both the head (next to apply)
// and the tail (most recently queued) entries.
module dir_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         tail_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    tail_ptr;
    logic [AW:0]      count_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only read once count says they were written.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign tail_ptr = wr_ptr_q - AW'(1);
    assign head_o   = mem_q[rd_ptr_q];
    assign tail_o   = mem_q[tail_ptr];
    assign count_o  = count_q;
    assign full_o   = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/ps2_dir_queue.sv
// PS/2 arrow-key decoder with reversal/repeat filter and a turn queue drained
// one entry per game tick. Define WASD_EN to also steer with W/S/A/D.
module ps2_dir_queue
    import ps2_dir_queue_pkg::*;
#(
    parameter int         DEPTH       = 4,
    parameter logic [1:0] DEFAULT_DIR = 2'b11
) (
    input  logic                     mclk,
    input  logic                     reset,
    input  logic                     rx_done_tick,
    input  logic [7:0]               rx_data,
    input  logic                     game_tick,
    output logic [1:0]               move,
    output logic                     move_strobe,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     overflow
);

    dec_state_e  state_q, state_d;
    logic        ev_valid;
    logic [1:0]  ev_dir;
    logic [1:0]  move_q, move_d;
    logic        move_strobe_q, move_strobe_d;
    logic        overflow_q, overflow_d;

    logic [1:0]  fifo_head, fifo_tail, ref_dir;
    logic        fifo_full, legal, push, pop;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        ev_valid = 1'b0;
        ev_dir   = DIR_UP;
        if (rx_done_tick) begin
            case (state_q)
                ST_IDLE: begin
                    case (rx_data)
                        SC_EXT:  state_d = ST_EXT;
                        SC_BRK:  state_d = ST_BRK;
`ifdef WASD_EN
                        SC_W:    begin ev_valid = 1'b1; ev_dir = DIR_UP;    end
                        SC_S:    begin ev_valid = 1'b1; ev_dir = DIR_DOWN;  end
                        SC_A:    begin ev_valid = 1'b1; ev_dir = DIR_LEFT;  end
                        SC_D:    begin ev_valid = 1'b1; ev_dir = DIR_RIGHT; end
`endif
                        default: state_d = ST_IDLE;
                    endcase
                end
                ST_EXT: begin
                    state_d = ST_IDLE;
                    case (rx_data)
                        SC_EXT:   state_d = ST_EXT;
                        SC_BRK:   state_d = ST_EXT_BRK;
                        SC_UP:    begin ev_valid = 1'b1; ev_dir = DIR_UP;    end
                        SC_DOWN:  begin ev_valid = 1'b1; ev_dir = DIR_DOWN;  end
                        SC_LEFT:  begin ev_valid = 1'b1; ev_dir = DIR_LEFT;  end
                        SC_RIGHT: begin ev_valid = 1'b1; ev_dir = DIR_RIGHT; end
                        default:  state_d = ST_IDLE;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The newest queued turn is what the snake will be doing when this event applies.
    assign ref_dir = (queue_count != '0) ? fifo_tail : move_q;
    assign legal   = ev_valid && (ev_dir != ref_dir) && (ev_dir != dir_opposite(ref_dir));
    assign pop     = game_tick && (queue_count != '0);
    assign push    = legal && (!fifo_full || pop);

    always_comb begin
        move_d        = pop ? fifo_head : move_q;
        move_strobe_d = pop && (fifo_head != move_q);
        overflow_d    = overflow_q || (legal && fifo_full && !pop);
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            move_q        <= DEFAULT_DIR;
            move_strobe_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            move_q        <= move_d;
            move_strobe_q <= move_strobe_d;
            overflow_q    <= overflow_d;
        end
    end

    dir_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk_i   (mclk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ev_dir),
        .head_o  (fifo_head),
        .tail_o  (fifo_tail),
        .count_o (queue_count),
        .full_o  (fifo_full)
    );

    assign move        = move_q;
    assign move_strobe = move_strobe_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_dir_queue.sv
// Scoreboard bench for ps2_dir_queue: a queue model predicts each applied turn,
// and every move_strobe pops and compares the next expected direction.
module tb_ps2_dir_queue;

    localparam int DEPTH = 4;
`ifdef WASD_EN
    localparam logic WASD = 1'b1;
`else
    localparam logic WASD = 1'b0;
`endif

    logic       mclk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       game_tick;
    logic [1:0] move;
    logic       move_strobe;
    logic [2:0] queue_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [1:0] mq[$];
    logic [1:0] exp_q[$];
    logic [1:0] mmove;
    logic       movf;

    ps2_dir_queue #(
        .DEPTH       (DEPTH),
        .DEFAULT_DIR (2'b11)
    ) dut (
        .mclk         (mclk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .game_tick    (game_tick),
        .move         (move),
        .move_strobe  (move_strobe),
        .queue_count  (queue_count),
        .overflow     (overflow)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b00;
            2'b10:   return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [7:0] arrow_code(input logic [1:0] d);
        case (d)
            2'b00:   return 8'h75;
            2'b01:   return 8'h72;
            2'b10:   return 8'h6B;
            default: return 8'h74;
        endcase
    endfunction

    always @(negedge mclk) begin
        if (!reset && move_strobe) begin
            if (exp_q.size() == 0) check("spurious_strobe", 32'd1, 32'd0);
            else                   check("strobe_move", {30'd0, move}, {30'd0, exp_q.pop_front()});
        end
    end

    // One clock of stimulus; ev/d tell the model which decoded event this byte should produce.
    task automatic cycle(input logic rx_v, input logic [7:0] b, input logic tk,
                         input logic ev, input logic [1:0] d);
        logic [1:0] r;
        logic       legal;
        logic       pop;
        @(negedge mclk);
        rx_done_tick = rx_v;
        rx_data      = b;
        game_tick    = tk;
        r     = (mq.size() > 0) ? mq[$] : mmove;
        legal = ev && (d != r) && (d != opposite(r));
        pop   = tk && (mq.size() > 0);
        if (pop) begin
            mmove = mq.pop_front();
            exp_q.push_back(mmove);
        end
        if (legal) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else                   movf = 1'b1;
        end
        @(posedge mclk);
        #1;
        rx_done_tick = 1'b0;
        game_tick    = 1'b0;
        check("move", {30'd0, move}, {30'd0, mmove});
        check("move_strobe", {31'd0, move_strobe}, {31'd0, pop});
        check("queue_count", {29'd0, queue_count}, mq.size());
        check("overflow", {31'd0, overflow}, {31'd0, movf});
    endtask

    task automatic press(input logic [1:0] d, input logic tk);
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 2'b00);
        cycle(1'b1, arrow_code(d), tk, 1'b1, d);
    endtask

    task automatic idle(input logic tk);
        cycle(1'b0, 8'h00, tk, 1'b0, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge mclk);
        reset = 1'b1;
        mq.delete();
        exp_q.delete();
        mmove = 2'b11;
        movf  = 1'b0;
        #1;
        check("rst_move", {30'd0, move}, 32'd3);
        check("rst_count", {29'd0, queue_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_strobe", {31'd0, move_strobe}, 32'd0);
        @(negedge mclk);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        game_tick    = 1'b0;
        mmove        = 2'b11;
        movf         = 1'b0;
        repeat (2) @(posedge mclk);

        // Single up turn applied on one tick.
        do_reset();
        press(2'b00, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Left from right is a reversal: nothing queued, no strobe.
        do_reset();
        press(2'b10, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Two queued turns drained over two ticks.
        do_reset();
        press(2'b00, 1'b0);
        press(2'b10, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Break sequences produce no events; decoder must be back in IDLE afterwards.
        do_reset();
        cycle(1'b1, 8'hF0, 1'b0, 1'b0, 2'b00);
        cycle(1'b1, 8'h1D, 1'b0, 1'b0, 2'b00);
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 2'b00);
        cycle(1'b1, 8'hF0, 1'b0, 1'b0, 2'b00);
        cycle(1'b1, 8'h75, 1'b0, 1'b0, 2'b00);
        idle(1'b1);
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 2'b00);
        press(2'b01, 1'b0);
        repeat (2) idle(1'b1);
        idle(1'b0);

        // Fill, overflow, then a push alongside a pop while full.
        do_reset();
        press(2'b00, 1'b0);
        press(2'b10, 1'b0);
        press(2'b01, 1'b0);
        press(2'b11, 1'b0);
        press(2'b00, 1'b0);
        check("full_count", {29'd0, queue_count}, 32'd4);
        check("full_overflow", {31'd0, overflow}, 32'd1);
        press(2'b00, 1'b1);
        check("push_pop_full_count", {29'd0, queue_count}, 32'd4);
        repeat (5) idle(1'b1);
        idle(1'b0);

        // Push and tick together on an empty queue: enqueued, not applied.
        do_reset();
        press(2'b00, 1'b1);
        idle(1'b1);
        idle(1'b0);

        // Push and pop together on a one-entry queue: reference is the popped entry.
        do_reset();
        press(2'b00, 1'b0);
        press(2'b10, 1'b1);
        press(2'b11, 1'b0);
        repeat (3) idle(1'b1);
        idle(1'b0);

        // Reset between E0 and 75 discards the prefix.
        do_reset();
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 2'b00);
        do_reset();
        cycle(1'b1, 8'h75, 1'b0, 1'b0, 2'b00);
        idle(1'b1);
        idle(1'b0);

        // W key steers up only in the WASD build.
        cycle(1'b1, 8'h1D, 1'b0, WASD, 2'b00);
        idle(1'b1);
        idle(1'b0);

        repeat (2) idle(1'b0);
        check("pending_strobes", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
